fft_frame_io: RTL and testbench
===============================

# fft_frame_io

Frame-level master for the FFT working-memory dual-port BRAM. It accepts a streaming frame of complex samples and writes them into the BRAM in bit-reversed address order. It then hands the memory to the FFT core and waits for completion. Finally it streams the transformed frame back out of the BRAM in natural order, with full valid/ready backpressure across the BRAM's one-cycle read latency.

## Interface
- POINTS, 1024, complex samples per frame; power of two, ≥ 4
- SAMPLE_WIDTH, 32, bits per sample (16 Re + 16 Im)
- ADDR_W, $clog2(POINTS), localparam address width
- FIFO_DEPTH, 3, localparam output-buffer depth

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  SAMPLE_WIDTH  input sample
- s_valid  in  1  input sample valid
- s_ready  out  1  block accepts input
- fft_start  out  1  one-cycle pulse: frame loaded, FFT core may run
- fft_done  in  1  one-cycle pulse from FFT core: results in BRAM
- mem_own  out  1  1 = this block drives BRAM ports; 0 = FFT core does
- mem_addr_a  out  ADDR_W  BRAM port A address (write)
- mem_din_a  out  SAMPLE_WIDTH  BRAM port A write data
- mem_we_a  out  1  BRAM port A write enable
- mem_addr_b  out  ADDR_W  BRAM port B address (read)
- mem_dout_b  in  SAMPLE_WIDTH  BRAM port B read data, valid one cycle after address
- m_data  out  SAMPLE_WIDTH  output sample
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts
- m_last  out  1  marks sample POINTS-1 of the frame

## Operation
- States are LOAD, COMPUTE and UNLOAD. Reset enters LOAD.
- **LOAD**
  - s_ready = 1 and mem_own = 1.
  - On each accept (s_valid & s_ready), drive combinationally: mem_we_a = 1, mem_addr_a = bitrev(wr_cnt), mem_din_a = s_data. Then wr_cnt increments.
  - On the accept with wr_cnt = POINTS-1, go to COMPUTE and clear wr_cnt.
- **COMPUTE**
  - s_ready = 0, mem_own = 0, mem_we_a = 0.
  - fft_start is 1 for the first cycle in COMPUTE only.
  - fft_done goes to UNLOAD.
- **UNLOAD**
  - mem_own = 1 and mem_we_a = 0.
  - mem_addr_b = rd_cnt (natural order).
  - A read issues in a cycle when rd_cnt < POINTS and fifo_count + inflight < FIFO_DEPTH.
  - Issued data is pushed into the output FIFO on the following cycle.
  - m_valid = FIFO non-empty. m_data = FIFO head. m_last = head index equals POINTS-1.
  - When the POINTS-1 beat is accepted, go to LOAD. All counters and the FIFO are cleared.
- fft_done is ignored in LOAD and UNLOAD.
- s_valid is ignored outside LOAD.
- bitrev reverses the ADDR_W bits: bit i of the address becomes bit ADDR_W-1-i.

## Timing
- Reset values:
  - state = LOAD, s_ready = 1, fft_start = 0, mem_own = 1.
  - mem_we_a = 0, mem_addr_a = 0, mem_din_a = 0, mem_addr_b = 0.
  - m_valid = 0, m_last = 0, m_data = 0.
  - All counters are 0 and the FIFO is empty.
- s_ready depends only on state, never on s_valid.
- Load throughput is 1 sample/cycle. Writes are zero-latency into the BRAM.
- fft_start is asserted in the cycle after the final accept.
- Unload latency:
  - A read issued in cycle t has data on mem_dout_b in cycle t+1. It is pushed at the end of t+1 and presented on m_valid in t+2.
  - The first m_valid is 2 cycles after entering UNLOAD, i.e. 3 cycles after the fft_done cycle.
- With m_ready held at 1, unload sustains 1 beat/cycle with no bubbles after the first.
- m_data, m_valid and m_last stay stable while m_valid & !m_ready.
- FIFO simultaneous push and pop in one cycle leaves the count unchanged.
- Asynchronous reset mid-frame discards all state. The BRAM contents are irrelevant afterwards; the next frame overwrites every address.

## Structure
- Shared package fft_pkg holds:
  - a state typedef enum for LOAD/COMPUTE/UNLOAD;
  - a bitrev function parameterised on ADDR_W;
  - a sample typedef packing 16-bit Re/Im.
- One natural sub-module: fft_out_fifo, a FIFO_DEPTH-entry synchronous FIFO with count output. It is reset by rst_n.

## Test plan
- **Reset:** with rst_n low, all outputs are at their reset values. After release, s_ready = 1 and mem_own = 1.
- **Load order (POINTS=8):** stream s_data = 0..7 back-to-back.
  - The writes land at addresses 0,4,2,6,1,5,3,7.
  - fft_start pulses exactly once, in the cycle after the 8th accept.
  - s_ready drops and mem_own = 0.
- **Unload, m_ready = 1:** preload BRAM[k] = 100+k and pulse fft_done.
  - m_valid first asserts 3 cycles after the fft_done cycle.
  - 8 consecutive beats follow: 100..107, with m_last only on 107.
  - The block then returns to LOAD.
- **Backpressure:** random m_ready (about 30% low).
  - The output sequence is 100..107 with no loss or duplication.
  - Outputs are held stable while stalled.
  - FIFO count never exceeds 3.
- **Spurious events:** an fft_done pulse in LOAD, and s_valid held high in COMPUTE/UNLOAD.
  - Neither causes a state change, a write, or a counter change.
- **Reset mid-operation:** assert rst_n low after 4 unload beats.
  - All outputs immediately return to their reset values.
  - A following full frame loads and unloads correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame I/O block.
package fft_pkg;

   // Output buffer depth: one beat in the FIFO, one read in flight, one spare.
   localparam int FIFO_DEPTH = 3;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

   // Frame phases: fill BRAM, hand it to the core, drain BRAM.
   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_UNLOAD  = 2'd2
   } fft_state_e;

   // One complex sample as stored in the BRAM.
   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } sample_t;

   // Reverse the low addr_w bits of addr. Upper result bits are zero.
   function automatic logic [31:0] bitrev(input logic [31:0] addr, input int addr_w);
      logic [31:0] a;
      logic [31:0] r;
      a = addr;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < addr_w) begin
            r = {r[30:0], a[0]};
            a = a >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Small synchronous FIFO with occupancy count, used to absorb the BRAM
// read latency in front of the output handshake.
module fft_out_fifo
   import fft_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = FIFO_DEPTH,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // A push into a full FIFO or a pop from an empty one is dropped.
   always_comb begin
      do_push = push && (count_q != CNT_FULL);
      do_pop  = pop && (count_q != '0);
   end

   // Storage, pointers and occupancy; clr empties the FIFO in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= next_ptr(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/fft_frame_io.sv
// Frame-level master for the FFT working-memory BRAM: loads a frame in
// bit-reversed order, hands the memory to the FFT core, then streams the
// result back out in natural order with valid/ready backpressure.
//
// Handshakes: a beat transfers on a rising edge where valid & ready are both
// high; valid never waits on ready, and a presented beat (data, last) holds
// until it transfers. s_ready depends only on the current phase.
module fft_frame_io
   import fft_pkg::*;
#(
   parameter int POINTS       = 1024,
   parameter int SAMPLE_WIDTH = 32,
   localparam int ADDR_W      = $clog2(POINTS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SAMPLE_WIDTH-1:0] s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic                    fft_start,
   input  logic                    fft_done,
   output logic                    mem_own,
   output logic [ADDR_W-1:0]       mem_addr_a,
   output logic [SAMPLE_WIDTH-1:0] mem_din_a,
   output logic                    mem_we_a,
   output logic [ADDR_W-1:0]       mem_addr_b,
   input  logic [SAMPLE_WIDTH-1:0] mem_dout_b,
   output logic [SAMPLE_WIDTH-1:0] m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic [1:0]              dbg_state,
   output logic [FIFO_CNT_W-1:0]   dbg_fifo_count
);

   localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(POINTS - 1);
   localparam logic [ADDR_W:0]   RD_END  = (ADDR_W + 1)'(POINTS);
   localparam logic [ADDR_W:0]   RD_LAST = (ADDR_W + 1)'(POINTS - 1);
   localparam logic [FIFO_CNT_W:0] BUF_LIMIT = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

   fft_state_e state_q;
   fft_state_e state_d;

   logic [ADDR_W-1:0]     wr_cnt_q;
   logic [ADDR_W:0]       rd_cnt_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic                  start_q;
   logic                  accept;
   logic                  rd_issue;
   logic                  pop;
   logic                  frame_end;
   logic [FIFO_CNT_W:0]   buf_used;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic                  fifo_empty;
   logic [SAMPLE_WIDTH:0] fifo_head;

   // Phase register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_LOAD;
      else        state_q <= state_d;
   end

   // Next phase and all phase-dependent outputs (BRAM ports, handshakes).
   always_comb begin
      state_d    = state_q;
      s_ready    = 1'b0;
      mem_own    = 1'b1;
      mem_we_a   = 1'b0;
      mem_addr_a = '0;
      mem_din_a  = '0;
      mem_addr_b = '0;
      accept     = 1'b0;
      rd_issue   = 1'b0;
      pop        = 1'b0;
      frame_end  = 1'b0;
      m_valid    = 1'b0;
      m_data     = '0;
      m_last     = 1'b0;
      buf_used   = {1'b0, fifo_count} + (FIFO_CNT_W + 1)'(inflight_q);
      case (state_q)
         ST_LOAD: begin
            s_ready = 1'b1;
            accept  = s_valid;
            if (accept) begin
               mem_we_a   = 1'b1;
               mem_addr_a = ADDR_W'(bitrev(32'(wr_cnt_q), ADDR_W));
               mem_din_a  = s_data;
               if (wr_cnt_q == WR_LAST) state_d = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            mem_own = 1'b0;
            if (fft_done) state_d = ST_UNLOAD;
         end
         ST_UNLOAD: begin
            mem_addr_b = rd_cnt_q[ADDR_W-1:0];
            // Only issue a read when its data is guaranteed a FIFO slot.
            rd_issue   = (rd_cnt_q < RD_END) && (buf_used < BUF_LIMIT);
            m_valid    = !fifo_empty;
            if (m_valid) begin
               m_data = fifo_head[SAMPLE_WIDTH-1:0];
               m_last = fifo_head[SAMPLE_WIDTH];
            end
            pop = m_valid && m_ready;
            if (pop && m_last) begin
               frame_end = 1'b1;
               state_d   = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Frame counters, start pulse and the read-in-flight tracker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q        <= '0;
         rd_cnt_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         start_q         <= 1'b0;
      end else begin
         start_q         <= (state_q == ST_LOAD) && (state_d == ST_COMPUTE);
         inflight_q      <= rd_issue;
         inflight_last_q <= rd_issue && (rd_cnt_q == RD_LAST);
         if (accept) wr_cnt_q <= (wr_cnt_q == WR_LAST) ? '0 : wr_cnt_q + ADDR_W'(1);
         if (rd_issue) rd_cnt_q <= rd_cnt_q + (ADDR_W + 1)'(1);
         if (frame_end) begin
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
         end
      end
   end

   // Read data lands one cycle after issue and is tagged with its last flag.
   fft_out_fifo #(
      .WIDTH (SAMPLE_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (frame_end),
      .push      (inflight_q),
      .push_data ({inflight_last_q, mem_dout_b}),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign fft_start      = start_q;
   assign dbg_state      = state_q;
   assign dbg_fifo_count = fifo_count;

endmodule

// File: tb/tb_fft_frame_io.sv
// Directed-plus-random bench for fft_frame_io with POINTS = 8. The bench
// models the BRAM and plays the FFT core during the compute phase.
module tb_fft_frame_io;

   localparam int N  = 8;
   localparam int AW = 3;
   localparam int W  = 32;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  s_data;
   logic          s_valid;
   logic          s_ready;
   logic          fft_start;
   logic          fft_done;
   logic          mem_own;
   logic [AW-1:0] mem_addr_a;
   logic [W-1:0]  mem_din_a;
   logic          mem_we_a;
   logic [AW-1:0] mem_addr_b;
   logic [W-1:0]  mem_dout_b;
   logic [W-1:0]  m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic [1:0]    dbg_state;
   logic [1:0]    dbg_fifo_count;

   // bench-side FFT core write port
   logic          core_we;
   logic [AW-1:0] core_addr;
   logic [W-1:0]  core_din;

   logic [W-1:0]  bram [N];
   logic [W-1:0]  frame_in [N];
   logic [W-1:0]  exp_q[$];
   bit            hold_sval;

   int n_checks;
   int n_pass;
   int n_fail;

   fft_frame_io #(.POINTS(N), .SAMPLE_WIDTH(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .fft_start      (fft_start),
      .fft_done       (fft_done),
      .mem_own        (mem_own),
      .mem_addr_a     (mem_addr_a),
      .mem_din_a      (mem_din_a),
      .mem_we_a       (mem_we_a),
      .mem_addr_b     (mem_addr_b),
      .mem_dout_b     (mem_dout_b),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_last         (m_last),
      .dbg_state      (dbg_state),
      .dbg_fifo_count (dbg_fifo_count)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // dual-port BRAM model: port A owned by the DUT or the core, port B reads
   always @(posedge clk) begin
      if (mem_own && mem_we_a) bram[mem_addr_a] <= mem_din_a;
      if (!mem_own && core_we) bram[core_addr] <= core_din;
      mem_dout_b <= bram[mem_addr_b];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // bit-reversed position of sample k, by repeated halving
   function automatic int rev(input int k);
      int v;
      int r;
      v = k;
      r = 0;
      for (int i = 0; i < AW; i++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   task automatic check_reset_values(input string ctx);
      check({ctx, "/s_ready"},    64'(s_ready), 64'd1);
      check({ctx, "/fft_start"},  64'(fft_start), 64'd0);
      check({ctx, "/mem_own"},    64'(mem_own), 64'd1);
      check({ctx, "/mem_we_a"},   64'(mem_we_a), 64'd0);
      check({ctx, "/mem_addr_a"}, 64'(mem_addr_a), 64'd0);
      check({ctx, "/mem_din_a"},  64'(mem_din_a), 64'd0);
      check({ctx, "/mem_addr_b"}, 64'(mem_addr_b), 64'd0);
      check({ctx, "/m_valid"},    64'(m_valid), 64'd0);
      check({ctx, "/m_last"},     64'(m_last), 64'd0);
      check({ctx, "/m_data"},     64'(m_data), 64'd0);
      check({ctx, "/state"},      64'(dbg_state), 64'd0);
      check({ctx, "/fifo_count"}, 64'(dbg_fifo_count), 64'd0);
   endtask

   // driver: stream frame_in with random idle gaps, checking each write
   task automatic load_frame(input int gap_pct);
      for (int k = 0; k < N; k++) begin
         for (int g = 0; g < 3; g++) begin
            if ($urandom_range(99) >= gap_pct) break;
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = $urandom;
            #1;
            check("load_idle_we", 64'(mem_we_a), 64'd0);
            check("load_idle_ready", 64'(s_ready), 64'd1);
         end
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = frame_in[k];
         #1;
         check("load_ready", 64'(s_ready), 64'd1);
         check("load_own", 64'(mem_own), 64'd1);
         check("load_we", 64'(mem_we_a), 64'd1);
         check("load_addr", 64'(mem_addr_a), 64'(rev(k)));
         check("load_din", 64'(mem_din_a), 64'(frame_in[k]));
      end
      @(negedge clk);
      s_valid = hold_sval;
      s_data  = $urandom;
      #1;
      check("start_pulse", 64'(fft_start), 64'd1);
      check("compute_ready", 64'(s_ready), 64'd0);
      check("compute_own", 64'(mem_own), 64'd0);
      check("compute_we", 64'(mem_we_a), 64'd0);
      check("compute_state", 64'(dbg_state), 64'd1);
      for (int k = 0; k < N; k++)
         check("bram_landing", 64'(bram[rev(k)]), 64'(frame_in[k]));
   endtask

   // driver: act as the FFT core, writing results and queueing expectations
   task automatic compute_phase(input bit fixed_results);
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         core_we   = 1'b1;
         core_addr = AW'(k);
         core_din  = fixed_results ? 32'(100 + k) : $urandom;
         exp_q.push_back(core_din);
         s_valid   = hold_sval;
         s_data    = $urandom;
         #1;
         check("start_once", 64'(fft_start), 64'd0);
         check("compute_we_hold", 64'(mem_we_a), 64'd0);
         check("compute_ready_hold", 64'(s_ready), 64'd0);
         check("compute_state_hold", 64'(dbg_state), 64'd1);
      end
      @(negedge clk);
      core_we  = 1'b0;
      fft_done = 1'b1;
   endtask

   // driver + scoreboard: drain the frame; optionally reset after abort_after beats
   task automatic unload_frame(input int ready_low_pct, input int abort_after);
      int          cyc;
      int          beats;
      bit          seen_first;
      bit          stalled;
      logic [W-1:0] prev_data;
      logic        prev_last;
      logic [W-1:0] exp;
      cyc = 0;
      beats = 0;
      seen_first = 0;
      stalled = 0;
      prev_data = '0;
      prev_last = 1'b0;
      while (beats < N && cyc < 200) begin
         @(negedge clk);
         cyc++;
         fft_done = hold_sval ? ($urandom_range(3) == 0) : 1'b0;
         s_valid  = hold_sval;
         s_data   = $urandom;
         m_ready  = ($urandom_range(99) >= ready_low_pct);
         #1;
         check("unload_state", 64'(dbg_state), 64'd2);
         check("unload_we", 64'(mem_we_a), 64'd0);
         check("unload_own", 64'(mem_own), 64'd1);
         check("unload_ready", 64'(s_ready), 64'd0);
         check("fifo_count_vs_valid", 64'(dbg_fifo_count != 2'd0), 64'(m_valid));
         if (!seen_first) begin
            if (cyc < 3) check("early_valid", 64'(m_valid), 64'd0);
            if (m_valid) begin
               seen_first = 1;
               check("first_valid_latency", 64'(cyc), 64'd3);
            end
         end else if (ready_low_pct == 0) begin
            check("no_bubble", 64'(m_valid), 64'd1);
         end
         if (stalled) begin
            check("stall_valid", 64'(m_valid), 64'd1);
            check("stall_data", 64'(m_data), 64'(prev_data));
            check("stall_last", 64'(m_last), 64'(prev_last));
         end
         if (m_valid && m_ready) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("out_data", 64'(m_data), 64'(exp));
            check("out_last", 64'(m_last), 64'(beats == N - 1));
            beats++;
         end
         stalled   = m_valid && !m_ready;
         prev_data = m_data;
         prev_last = m_last;
         if (abort_after > 0 && beats == abort_after) begin
            @(posedge clk);
            #2;
            rst_n   = 1'b0;
            s_valid = 1'b0;
            m_ready = 1'b0;
            fft_done = 1'b0;
            #1;
            check_reset_values("midreset");
            @(negedge clk);
            check_reset_values("midreset_hold");
            rst_n = 1'b1;
            exp_q.delete();
            return;
         end
      end
      if (beats < N) check("unload_timeout", 64'(beats), 64'(N));
      @(negedge clk);
      s_valid  = 1'b0;
      m_ready  = 1'b0;
      fft_done = 1'b0;
      #1;
      check("back_to_load", 64'(dbg_state), 64'd0);
      check("back_ready", 64'(s_ready), 64'd1);
      check("back_own", 64'(mem_own), 64'd1);
      check("back_valid", 64'(m_valid), 64'd0);
      check("back_fifo", 64'(dbg_fifo_count), 64'd0);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic fill_random();
      for (int k = 0; k < N; k++) frame_in[k] = $urandom;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      s_data    = '0;
      s_valid   = 1'b0;
      fft_done  = 1'b0;
      m_ready   = 1'b0;
      core_we   = 1'b0;
      core_addr = '0;
      core_din  = '0;
      hold_sval = 1'b0;

      // reset
      repeat (2) @(negedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("post_reset_ready", 64'(s_ready), 64'd1);
      check("post_reset_own", 64'(mem_own), 64'd1);

      // frame 1: ramp 0..7 back-to-back, results 100..107, m_ready held high
      for (int k = 0; k < N; k++) frame_in[k] = 32'(k);
      load_frame(0);
      compute_phase(1'b1);
      unload_frame(0, 0);

      // frame 2: random input with gaps, random backpressure
      fill_random();
      load_frame(30);
      compute_phase(1'b1);
      unload_frame(30, 0);

      // frame 3: spurious fft_done in LOAD, s_valid held outside LOAD
      @(negedge clk);
      fft_done = 1'b1;
      #1;
      check("spur_done_we", 64'(mem_we_a), 64'd0);
      @(negedge clk);
      fft_done = 1'b0;
      #1;
      check("spur_done_state", 64'(dbg_state), 64'd0);
      check("spur_done_start", 64'(fft_start), 64'd0);
      check("spur_done_ready", 64'(s_ready), 64'd1);
      hold_sval = 1'b1;
      fill_random();
      load_frame(20);
      compute_phase(1'b0);
      unload_frame(30, 0);
      hold_sval = 1'b0;

      // frame 4: reset after four beats, then a clean full frame
      fill_random();
      load_frame(0);
      compute_phase(1'b0);
      unload_frame(0, 4);
      @(negedge clk);
      #1;
      check("after_reset_state", 64'(dbg_state), 64'd0);
      fill_random();
      load_frame(10);
      compute_phase(1'b0);
      unload_frame(20, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
